// File: rtl/pi_uart_tx.sv
// Byte-wide UART transmitter (FPGA -> Raspberry Pi): valid/ready byte input, one
// start bit, 8 data bits LSB first, optional parity, 1 or 2 stop bits on out_tx.
module pi_uart_tx #(
  parameter int unsigned CLK_HZ    = 50_000_000,
  parameter int unsigned BAUD      = 115200,
  parameter int unsigned PARITY    = 0,
  parameter int unsigned STOP_BITS = 1
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       in_valid,
  input  logic [7:0] in_data,
  output logic       out_ready,
  output logic       out_busy,
  output logic       out_tx
);

  localparam int unsigned DIV      = (CLK_HZ + BAUD / 2) / BAUD;
  localparam int unsigned CW       = (DIV > 1) ? $clog2(DIV) : 1;
  localparam int unsigned PMODE    = (PARITY == 1 || PARITY == 2) ? PARITY : 0;
  localparam bit          TWO_STOP = (STOP_BITS == 2);

  typedef enum logic [2:0] {IDLE, START, DATA, PAR, STOP} state_t;

  state_t        state;
  logic [CW-1:0] baud;
  logic [2:0]    bit_idx;
  logic          stop_idx;
  logic [7:0]    shreg;
  logic          baud_end;
  logic          par_bit;

  assign baud_end = (baud == CW'(DIV - 1));
  assign par_bit  = (^shreg) ^ (PMODE == 2);

  always_ff @(posedge clk) begin
    if (rst) begin
      state     <= IDLE;
      baud      <= '0;
      bit_idx   <= '0;
      stop_idx  <= 1'b0;
      shreg     <= '0;
      out_tx    <= 1'b1;
      out_ready <= 1'b1;
      out_busy  <= 1'b0;
    end else begin
      // Baud counter only runs inside a frame; it is already 0 on entry from IDLE.
      if (state != IDLE) begin
        if (baud_end) baud <= '0;
        else          baud <= baud + 1'b1;
      end
      case (state)
        IDLE: begin
          if (in_valid) begin
            shreg     <= in_data;
            state     <= START;
            out_tx    <= 1'b0;
            out_busy  <= 1'b1;
            out_ready <= 1'b0;
            baud      <= '0;
          end
        end
        START: begin
          if (baud_end) begin
            state   <= DATA;
            bit_idx <= '0;
            out_tx  <= shreg[0];
          end
        end
        DATA: begin
          if (baud_end) begin
            if (bit_idx == 3'd7) begin
              bit_idx <= '0;
              if (PMODE != 0) begin
                state  <= PAR;
                out_tx <= par_bit;
              end else begin
                state    <= STOP;
                stop_idx <= 1'b0;
                out_tx   <= 1'b1;
              end
            end else begin
              bit_idx <= bit_idx + 3'd1;
              out_tx  <= shreg[bit_idx + 3'd1];
            end
          end
        end
        PAR: begin
          if (baud_end) begin
            state    <= STOP;
            stop_idx <= 1'b0;
            out_tx   <= 1'b1;
          end
        end
        STOP: begin
          if (baud_end) begin
            if (!TWO_STOP || stop_idx) begin
              state     <= IDLE;
              out_busy  <= 1'b0;
              out_ready <= 1'b1;
            end else begin
              stop_idx <= 1'b1;
            end
          end
        end
        default: begin
          state     <= IDLE;
          out_tx    <= 1'b1;
          out_busy  <= 1'b0;
          out_ready <= 1'b1;
        end
      endcase
    end
  end

endmodule
